tsmp_decap_ctrl: RTL

//  Parametrised TSMP decapsulator for the controller interactive path. Strips the TSMP head beat and

---
 rtl/tsmp_decap_ctrl_pkg.sv | 57 +++++
 rtl/tsmp_decap_ctrl_sat_cnt.sv | 27 ++
 rtl/tsmp_decap_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/tsmp_decap_ctrl_pkg.sv
// Shared TSMP definitions: subtype codes, beat flags, switch packet types,
// metadata field positions, FSM states and the synthetic-tail beat.
// Used by both the decapsulation and encapsulation sides.
package tsmp_pkg;

   localparam int BEAT_W = 134;

   // TSMP head subtypes
   localparam logic [7:0] SUB_ARP  = 8'h00;
   localparam logic [7:0] SUB_NMAC = 8'h02;
   localparam logic [7:0] SUB_PTP  = 8'h05;

   // Beat flags carried in [133:132]
   localparam logic [1:0] FLAG_HEAD = 2'b01;
   localparam logic [1:0] FLAG_BODY = 2'b11;
   localparam logic [1:0] FLAG_TAIL = 2'b10;

   // Switch packet types written into the metadata beat
   localparam logic [2:0] PKT_ARP_ACK = 3'b110;
   localparam logic [2:0] PKT_NMAC    = 3'b101;
   localparam logic [2:0] PKT_PTP     = 3'b100;

   // Metadata beat layout
   localparam int          META_HDR_LO  = 128;
   localparam logic [5:0]  META_HDR     = 6'b010000;
   localparam int          TYPE_LO      = 125;
   localparam int          INJ_LO       = 120;
   localparam int          OUTPORT_LO   = 111;
   localparam int          LOOKUP_BIT   = 110;
   localparam int          META_VLD_BIT = 109;

   // Tail emitted when a frame is cut short
   localparam logic [BEAT_W-1:0] SYNTH_TAIL = {FLAG_TAIL, 132'b0};

   typedef enum logic [1:0] {
      IDLE_S  = 2'd0,
      TRANS_S = 2'd1,
      DROP_S  = 2'd2
   } state_e;

   // Assemble the switch metadata beat that replaces the TSMP head
   function automatic logic [BEAT_W-1:0] build_meta(input logic [2:0] pkt_type,
                                                    input logic [4:0] inj_addr,
                                                    input logic [8:0] outport,
                                                    input logic       lookup_en);
      logic [BEAT_W-1:0] m;
      m = '0;
      m[META_HDR_LO +: 6] = META_HDR;
      m[TYPE_LO     +: 3] = pkt_type;
      m[INJ_LO      +: 5] = inj_addr;
      m[OUTPORT_LO  +: 9] = outport;
      m[LOOKUP_BIT]       = lookup_en;
      m[META_VLD_BIT]     = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/tsmp_decap_ctrl_sat_cnt.sv
// Saturating statistics counter: holds at all-ones, clear wins over increment.
module tsmp_sat_cnt #(
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] ov_cnt
);

   logic [CNT_W-1:0] cnt_q;

   // Count events, stopping at the maximum value
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else if (i_clr) begin
         cnt_q <= '0;
      end else if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign ov_cnt = cnt_q;

endmodule

// File: rtl/tsmp_decap_ctrl.sv
// TSMP decapsulator for the controller interactive path. Replaces the TSMP
// head with a switch metadata beat (ARP-ack / NMAC-config / PTP), forwards
// the body with one cycle of latency, discards unwanted frames whole, closes
// truncated or over-long frames with a synthetic tail and keeps statistics.
// Optional feature macro: TSMP_DECAP_TYPE_CNT_EN adds per-type frame counters.
module tsmp_decap_ctrl
   import tsmp_pkg::*;
#(
   parameter int         PORT_NUM      = 8,
   parameter int         MAX_FRAME_CYC = 128,
   parameter int         CNT_W         = 16,
   parameter logic [4:0] INJ_ADDR      = 5'd0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [133:0]       iv_data,
   input  logic               i_data_wr,
   input  logic [2:0]         iv_subtype_en,
   input  logic               i_cnt_clr,
   output logic [133:0]       ov_data,
   output logic               o_data_wr,
   output logic [CNT_W-1:0]   ov_drop_cnt,
`ifdef TSMP_DECAP_TYPE_CNT_EN
   output logic [CNT_W-1:0]   ov_arp_cnt,
   output logic [CNT_W-1:0]   ov_nmac_cnt,
   output logic [CNT_W-1:0]   ov_ptp_cnt,
`endif
   output logic [CNT_W-1:0]   ov_err_cnt
);

   localparam int               WD_W     = $clog2(MAX_FRAME_CYC) + 1;
   localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(MAX_FRAME_CYC - 1);
   localparam logic [7:0]       PORT_LIM = 8'(PORT_NUM);

   state_e              state_q;
   logic [133:0]        data_q;
   logic                wr_q;
   logic [WD_W-1:0]     wd_q;

   logic                head_v;
   logic                tail_v;
   logic                wd_lim;
   logic                cls_ok;
   logic                cls_arp;
   logic                cls_nmac;
   logic                cls_ptp;
   logic [133:0]        cls_meta;
   logic                drop_inc;
   logic                err_inc;

   assign head_v = i_data_wr && (iv_data[133:132] == FLAG_HEAD);
   assign tail_v = i_data_wr && (iv_data[133:132] == FLAG_TAIL);
   assign wd_lim = (wd_q == WD_LIM);

   // Classify the incoming head against subtype codes, runtime enables and port range
   always_comb begin
      cls_arp  = 1'b0;
      cls_nmac = 1'b0;
      cls_ptp  = 1'b0;
      cls_meta = '0;
      case (iv_data[15:8])
         SUB_ARP: begin
            if (iv_subtype_en[0] && (iv_data[7:0] < PORT_LIM)) begin
               cls_arp  = 1'b1;
               cls_meta = build_meta(PKT_ARP_ACK, INJ_ADDR, 9'h001 << iv_data[7:0], 1'b0);
            end
         end
         SUB_NMAC: begin
            if (iv_subtype_en[1]) begin
               cls_nmac = 1'b1;
               cls_meta = build_meta(PKT_NMAC, INJ_ADDR, 9'h000, 1'b0);
            end
         end
         SUB_PTP: begin
            if (iv_subtype_en[2]) begin
               cls_ptp  = 1'b1;
               cls_meta = build_meta(PKT_PTP, INJ_ADDR, 9'h000, 1'b1);
            end
         end
         default: ;
      endcase
      cls_ok = cls_arp | cls_nmac | cls_ptp;
   end

   assign drop_inc = head_v && (state_q != TRANS_S) && !cls_ok;
   assign err_inc  = (state_q == TRANS_S) && i_data_wr && (head_v || (!tail_v && wd_lim));

   // Frame FSM with registered output beat and frame-length watchdog
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= IDLE_S;
         data_q  <= '0;
         wr_q    <= 1'b0;
         wd_q    <= '0;
      end else begin
         data_q <= '0;
         wr_q   <= 1'b0;
         case (state_q)
            IDLE_S, DROP_S: begin
               if (head_v) begin
                  if (cls_ok) begin
                     data_q  <= cls_meta;
                     wr_q    <= 1'b1;
                     wd_q    <= WD_W'(1);
                     state_q <= TRANS_S;
                  end else begin
                     state_q <= DROP_S;
                  end
               end else if ((state_q == DROP_S) && tail_v) begin
                  state_q <= IDLE_S;
               end
            end
            TRANS_S: begin
               if (i_data_wr) begin
                  if (head_v) begin
                     // New head before a tail: close the open frame, discard the new one
                     data_q  <= SYNTH_TAIL;
                     wr_q    <= 1'b1;
                     wd_q    <= '0;
                     state_q <= DROP_S;
                  end else if (tail_v) begin
                     // A real tail is always honoured, even on the limit beat
                     data_q  <= iv_data;
                     wr_q    <= 1'b1;
                     wd_q    <= '0;
                     state_q <= IDLE_S;
                  end else if (wd_lim) begin
                     data_q  <= SYNTH_TAIL;
                     wr_q    <= 1'b1;
                     wd_q    <= '0;
                     state_q <= DROP_S;
                  end else begin
                     data_q  <= iv_data;
                     wr_q    <= 1'b1;
                     wd_q    <= wd_q + WD_W'(1);
                  end
               end
            end
            default: begin
               state_q <= IDLE_S;
               wd_q    <= '0;
            end
         endcase
      end
   end

   assign ov_data   = data_q;
   assign o_data_wr = wr_q;

   tsmp_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_inc  (drop_inc),
      .i_clr  (i_cnt_clr),
      .ov_cnt (ov_drop_cnt)
   );

   tsmp_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_inc  (err_inc),
      .i_clr  (i_cnt_clr),
      .ov_cnt (ov_err_cnt)
   );

`ifdef TSMP_DECAP_TYPE_CNT_EN
   logic emit_ok;
   assign emit_ok = head_v && (state_q != TRANS_S);

   tsmp_sat_cnt #(.CNT_W(CNT_W)) u_arp_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_inc  (emit_ok && cls_arp),
      .i_clr  (i_cnt_clr),
      .ov_cnt (ov_arp_cnt)
   );

   tsmp_sat_cnt #(.CNT_W(CNT_W)) u_nmac_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_inc  (emit_ok && cls_nmac),
      .i_clr  (i_cnt_clr),
      .ov_cnt (ov_nmac_cnt)
   );

   tsmp_sat_cnt #(.CNT_W(CNT_W)) u_ptp_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_inc  (emit_ok && cls_ptp),
      .i_clr  (i_cnt_clr),
      .ov_cnt (ov_ptp_cnt)
   );
`endif

endmodule
